spike_synapse_accum: RTL and testbench

Synaptic input stage directly upstream of the leaky integrate-and-fire neuron. Accepts a frame of presynaptic spike bits and sums the programmable signed weight of every spiking input, one input per cycle. Clamps the sum to an unsigned 8-bit current, which drives the neuron's current input. The current is held between frames so the neuron can sample it every cycle.

---
 rtl/spike_synapse_accum_pkg.sv | 25 ++
 rtl/spike_synapse_accum_prio.sv | 27 ++
 rtl/spike_synapse_accum.sv | 152 +++++++++++++++
 tb/tb_spike_synapse_accum.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spike_synapse_accum_pkg.sv
// Shared definitions for the synaptic input stage and the neuron stage
// that consumes its current.
//   - Default sizes for N_IN / W_WIDTH / CUR_WIDTH.
//   - FSM state constants (IDLE, SCAN) and the state type.
//   - Accumulator width helper and clamp-limit constant.
package spike_synapse_accum_pkg;

  localparam int N_IN_DEF      = 8;
  localparam int W_WIDTH_DEF   = 8;
  localparam int CUR_WIDTH_DEF = 8;

  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_SCAN = 1'b1;

  // Signed accumulator wide enough that N_IN weights of W_WIDTH bits can
  // never overflow it.
  function automatic int acc_width(input int n_in, input int w_width);
    return w_width + $clog2(n_in) + 1;
  endfunction

  localparam int ACC_WIDTH_DEF = acc_width(N_IN_DEF, W_WIDTH_DEF);
  localparam int CUR_MAX_DEF   = (1 << CUR_WIDTH_DEF) - 1;

endpackage

// File: rtl/spike_synapse_accum_prio.sv
// spike_prio_enc: lowest-set-bit priority encoder.
// Ports:
//   bits  - input vector (N bits)
//   idx   - index of the lowest set bit ('0 when none set)
//   found - high when any bit of bits is set
module spike_prio_enc #(
  parameter int N  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  bits,
  output logic [IW-1:0] idx,
  output logic          found
);

  // Scan from the top down so the lowest set bit is the last to assign.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (bits[i]) begin
        idx   = IW'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spike_synapse_accum.sv
// spike_synapse_accum: sums the programmable signed weight of every
// spiking presynaptic input in a frame, one input per cycle, and clamps
// the result to an unsigned current held for the downstream neuron.
//
// Build option: define ZERO_SKIP_EN to visit only the set bits of the
// frame (lowest first) instead of all N_IN inputs. Results are identical;
// only the scan length changes.
//
// Ports:
//   clk, rst          - clock (posedge) and asynchronous active-high reset
//   spikes_in         - presynaptic spike frame, bit i = input i
//   spikes_valid      - frame offered
//   spikes_ready      - block can accept a frame (IDLE only)
//   wr_en/wr_addr/wr_data - weight write port, usable in any state
//   current           - clamped synaptic current, held until next frame ends
//   current_valid     - one-cycle pulse after a frame completes
//   busy              - scan in progress (= !spikes_ready)
//   state_dbg         - FSM state for observation
//
// Handshake: a frame transfers on a rising clk edge where spikes_valid and
// spikes_ready are both high. spikes_ready depends only on state, never on
// spikes_valid. While busy, spikes_valid is ignored and nothing is queued;
// the source must keep offering until it sees ready.
module spike_synapse_accum
  import spike_synapse_accum_pkg::*;
#(
  parameter int N_IN      = N_IN_DEF,
  parameter int W_WIDTH   = W_WIDTH_DEF,
  parameter int CUR_WIDTH = CUR_WIDTH_DEF,
  localparam int AW       = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_IN-1:0]      spikes_in,
  input  logic                 spikes_valid,
  output logic                 spikes_ready,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [W_WIDTH-1:0]   wr_data,
  output logic [CUR_WIDTH-1:0] current,
  output logic                 current_valid,
  output logic                 busy,
  output state_t               state_dbg
);

  localparam int ACC_W = acc_width(N_IN, W_WIDTH);
  localparam int CMP_W = (ACC_W > CUR_WIDTH) ? ACC_W + 1 : CUR_WIDTH + 1;

  state_t                     state;
  logic [N_IN-1:0]            mask;
  logic signed [ACC_W-1:0]    acc;
  logic signed [W_WIDTH-1:0]  weights [N_IN];

  logic [AW-1:0]              sel_idx;
  logic                       sel_hit;
  logic [N_IN-1:0]            mask_next;
  logic                       last;
  logic signed [ACC_W-1:0]    term;
  logic signed [ACC_W-1:0]    sum_next;

  function automatic logic [CUR_WIDTH-1:0] clamp(input logic signed [ACC_W-1:0] s);
    logic signed [CMP_W-1:0] se;
    logic signed [CMP_W-1:0] lim;
    se = CMP_W'(s);
    lim = '0;
    lim[CUR_WIDTH-1:0] = '1;
    if (se < 0)
      return '0;
    else if (se > lim)
      return '1;
    else
      return se[CUR_WIDTH-1:0];
  endfunction

`ifdef ZERO_SKIP_EN
  // Remaining mask shrinks by one bit per edge; the frame ends on the edge
  // that clears the last bit (or immediately for an empty frame).
  spike_prio_enc #(.N(N_IN), .IW(AW)) u_prio (
    .bits  (mask),
    .idx   (sel_idx),
    .found (sel_hit)
  );

  always_comb begin
    mask_next = mask & ~({{(N_IN-1){1'b0}}, 1'b1} << sel_idx);
    last      = (mask_next == '0);
  end
`else
  logic [AW-1:0] idx;

  always_comb begin
    sel_idx   = idx;
    sel_hit   = mask[idx];
    mask_next = mask;
    last      = (idx == AW'(N_IN - 1));
  end
`endif

  // Weight read happens before the same-edge write lands, so a write to
  // the index being scanned takes effect only for later reads.
  always_comb begin
    term     = sel_hit ? ACC_W'(weights[sel_idx]) : '0;
    sum_next = acc + term;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      mask          <= '0;
      acc           <= '0;
      current       <= '0;
      current_valid <= 1'b0;
      for (int i = 0; i < N_IN; i++) weights[i] <= '0;
`ifndef ZERO_SKIP_EN
      idx           <= '0;
`endif
    end else begin
      current_valid <= 1'b0;
      if (wr_en) weights[wr_addr] <= wr_data;
      case (state)
        ST_IDLE: begin
          if (spikes_valid) begin
            mask  <= spikes_in;
            acc   <= '0;
            state <= ST_SCAN;
`ifndef ZERO_SKIP_EN
            idx   <= '0;
`endif
          end
        end
        default: begin
          mask <= mask_next;
          if (last) begin
            current       <= clamp(sum_next);
            current_valid <= 1'b1;
            state         <= ST_IDLE;
          end else begin
            acc <= sum_next;
`ifndef ZERO_SKIP_EN
            idx <= idx + AW'(1);
`endif
          end
        end
      endcase
    end
  end

  assign spikes_ready = (state == ST_IDLE);
  assign busy         = (state != ST_IDLE);
  assign state_dbg    = state;

endmodule

// File: tb/tb_spike_synapse_accum.sv
module tb_spike_synapse_accum;

  localparam int N_IN = 8;
  localparam int CUR_MAX = 255;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] spikes_in = '0;
  logic       spikes_valid = 1'b0;
  logic       spikes_ready;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic [7:0] current;
  logic       current_valid;
  logic       busy;
  logic [0:0] dbg_state;

  spike_synapse_accum dut (
    .clk           (clk),
    .rst           (rst),
    .spikes_in     (spikes_in),
    .spikes_valid  (spikes_valid),
    .spikes_ready  (spikes_ready),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .current       (current),
    .current_valid (current_valid),
    .busy          (busy),
    .state_dbg     (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int         n_checks = 0;
  int         n_errors = 0;
  int         w_model [N_IN];
  logic [7:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: sum of weights of set bits, clamped to [0, 255].
  function automatic int model_current(input logic [7:0] s);
    int sum = 0;
    for (int i = 0; i < N_IN; i++) if (s[i]) sum += w_model[i];
    if (sum < 0) return 0;
    if (sum > CUR_MAX) return CUR_MAX;
    return sum;
  endfunction

  function automatic int model_latency(input logic [7:0] s);
`ifdef ZERO_SKIP_EN
    int pop = $countones(s);
    return (pop == 0) ? 1 : pop;
`else
    return N_IN;
`endif
  endfunction

  // ---------------- driver tasks (called #1 after a posedge) ----------------
  task automatic write_w(input int a, input int d);
    wr_en   = 1'b1;
    wr_addr = a[2:0];
    wr_data = d[7:0];
    @(posedge clk); #1;
    wr_en   = 1'b0;
    w_model[a] = d;
  endtask

  task automatic run_frame(input logic [7:0] s, input bit hold_valid);
    int k = 0;
    bit done = 0;
    check("ready_idle", spikes_ready, 1);
    exp_q.push_back(8'(model_current(s)));
    spikes_in    = s;
    spikes_valid = 1'b1;
    @(posedge clk); #1;
    if (!hold_valid) spikes_valid = 1'b0;
    while (!done && k < 200) begin
      check("busy_scan", busy, 1);
      @(posedge clk); #1;
      k++;
      if (current_valid) done = 1;
    end
    if (!done) begin
      n_checks++;
      n_errors++;
      $display("FAIL frame_timeout: got no current_valid expected pulse");
      void'(exp_q.pop_front());
    end else begin
      check("latency", k, model_latency(s));
      check("current", current, exp_q.pop_front());
      check("ready_with_valid", spikes_ready, 1);
    end
    spikes_valid = 1'b0;
    @(posedge clk); #1;
    check("valid_single_pulse", current_valid, 0);
    check("current_held", current, model_current(s));
    check("idle_after", busy, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int wa_edge [2];
    int wa_addr [2];
    int wa_data [2];
    int k;
    bit done;
    logic [7:0] s;

    for (int i = 0; i < N_IN; i++) w_model[i] = 0;
    #12;
    check("rst_current", current, 0);
    check("rst_valid", current_valid, 0);
    check("rst_ready", spikes_ready, 1);
    check("rst_busy", busy, 0);
    @(posedge clk); #3;
    rst = 1'b0;
    @(posedge clk); #1;

    // Weights come out of reset as zero.
    run_frame(8'hFF, 0);

    // w[i] = 10*i, frame A5 -> 140.
    for (int i = 0; i < N_IN; i++) write_w(i, 10 * i);
    run_frame(8'hA5, 0);

    // Mid-cycle reset clears outputs without a clock edge.
    #3 rst = 1'b1;
    #1;
    check("midrst_current", current, 0);
    check("midrst_valid", current_valid, 0);
    check("midrst_ready", spikes_ready, 1);
    check("midrst_busy", busy, 0);
    #2 rst = 1'b0;
    for (int i = 0; i < N_IN; i++) w_model[i] = 0;
    @(posedge clk); #1;

    // Positive saturation.
    for (int i = 0; i < N_IN; i++) write_w(i, 100);
    run_frame(8'hFF, 0);

    // Negative sum clamps to zero.
    write_w(0, 30);
    write_w(1, -50);
    run_frame(8'h03, 0);

    // Weight writes while the frame is being scanned.
    write_w(7, 1);
    write_w(0, 2);
`ifdef ZERO_SKIP_EN
    wa_edge[0] = 1; wa_addr[0] = 7; wa_data[0] = 5;
    wa_edge[1] = 2; wa_addr[1] = 0; wa_data[1] = 9;
`else
    wa_edge[0] = 1; wa_addr[0] = 0; wa_data[0] = 9;
    wa_edge[1] = 3; wa_addr[1] = 7; wa_data[1] = 5;
`endif
    spikes_in    = 8'h81;
    spikes_valid = 1'b1;
    @(posedge clk); #1;
    spikes_valid = 1'b0;
    k = 0;
    done = 0;
    while (!done && k < 200) begin
      wr_en = 1'b0;
      for (int j = 0; j < 2; j++) begin
        if (wa_edge[j] == k + 1) begin
          wr_en   = 1'b1;
          wr_addr = wa_addr[j][2:0];
          wr_data = wa_data[j][7:0];
        end
      end
      @(posedge clk); #1;
      k++;
      if (current_valid) done = 1;
    end
    wr_en = 1'b0;
    check("wscan_done", done, 1);
    check("wscan_latency", k, model_latency(8'h81));
    check("wscan_current", current, 7);
    w_model[0] = 9;
    w_model[7] = 5;
    @(posedge clk); #1;

    // Backpressure: valid held high through the scan.
    run_frame(8'h5A, 1);

    // Empty frame.
    run_frame(8'h00, 0);

    // Abort: reset asserted before E4.
    run_frame(8'h0F, 0);
    spikes_in    = 8'hFF;
    spikes_valid = 1'b1;
    @(posedge clk); #1;
    spikes_valid = 1'b0;
    for (int e = 0; e < 3; e++) begin
      @(posedge clk); #1;
      check("abort_no_early_valid", current_valid, 0);
    end
    #2 rst = 1'b1;
    #1;
    check("abort_current", current, 0);
    check("abort_ready", spikes_ready, 1);
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b0;
    for (int i = 0; i < N_IN; i++) w_model[i] = 0;
    for (int e = 0; e < 10; e++) begin
      @(posedge clk); #1;
      check("abort_valid", current_valid, 0);
      check("abort_current_hold", current, 0);
    end

    // Randomized frames against the reference model.
    for (int i = 0; i < N_IN; i++) write_w(i, int'($urandom_range(0, 255)) - 128);
    for (int it = 0; it < 30; it++) begin
      int nw = $urandom_range(0, 3);
      for (int j = 0; j < nw; j++) begin
        if ($urandom_range(0, 3) == 0)
          write_w($urandom_range(0, 7), int'($urandom_range(60, 127)));
        else
          write_w($urandom_range(0, 7), int'($urandom_range(0, 255)) - 128);
      end
      s = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 9) == 0) s = 8'h00;
      run_frame(s, $urandom_range(0, 1) == 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
